// File: rtl/prefetch_responder.sv
// Memory-side prefetch responder: dedups and queues prefetch addresses, issues one
// memory read at a time, and keeps returned words in a small fully-associative buffer.
module prefetch_responder #(
    parameter int QDEPTH      = 4,
    parameter int BUF_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        memRequest,
    input  logic [15:0] requestAddress,
    output logic        memReadReq,
    output logic [15:0] memReadAddr,
    input  logic        memReadAck,
    input  logic        memReadValid,
    input  logic [15:0] memReadData,
    input  logic        lookupValid,
    input  logic [15:0] lookupAddr,
    output logic        lookupHit,
    output logic [15:0] lookupData,
    input  logic        storeValid,
    input  logic [15:0] storeAddr,
    output logic        queueFull,
    output logic [7:0]  dropCount
);
    localparam int QA = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int BA = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [QA-1:0]          head_q, head_d, tail_q, tail_d;
    logic [QA:0]            count_q, count_d;
    logic [15:0]            q_mem_q [QDEPTH];
    logic [15:0]            q_mem_d [QDEPTH];
    logic [15:0]            inflight_addr_q, inflight_addr_d;
    logic                   inflight_kill_q, inflight_kill_d;
    logic [BUF_ENTRIES-1:0] buf_valid_q, buf_valid_d;
    logic [15:0]            buf_addr_q [BUF_ENTRIES];
    logic [15:0]            buf_addr_d [BUF_ENTRIES];
    logic [15:0]            buf_data_q [BUF_ENTRIES];
    logic [15:0]            buf_data_d [BUF_ENTRIES];
    logic [BA-1:0]          rep_ptr_q, rep_ptr_d;
    logic                   lookup_hit_q, lookup_hit_d;
    logic [15:0]            lookup_data_q, lookup_data_d;
    logic                   queue_full_q, queue_full_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic        in_flight, dup, pop, push, fill, lk_hit;
    logic [15:0] lk_data;
    logic [QA-1:0] q_off;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        q_mem_d         = q_mem_q;
        inflight_addr_d = inflight_addr_q;
        inflight_kill_d = inflight_kill_q;
        buf_valid_d     = buf_valid_q;
        buf_addr_d      = buf_addr_q;
        buf_data_d      = buf_data_q;
        rep_ptr_d       = rep_ptr_q;
        drop_count_d    = drop_count_q;
        lk_hit          = 1'b0;
        lk_data         = '0;
        q_off           = '0;
        fill            = 1'b0;

        in_flight = (state_q != IDLE);

        // Dedup and lookup both see the pre-edge queue/buffer contents.
        dup = in_flight && (inflight_addr_q == requestAddress);
        for (int i = 0; i < QDEPTH; i++) begin
            q_off = QA'(i) - head_q;
            if (({1'b0, q_off} < count_q) && (q_mem_q[i] == requestAddress))
                dup = 1'b1;
        end
        for (int i = 0; i < BUF_ENTRIES; i++) begin
            if (buf_valid_q[i] && (buf_addr_q[i] == requestAddress))
                dup = 1'b1;
            if (buf_valid_q[i] && (buf_addr_q[i] == lookupAddr)) begin
                lk_hit  = 1'b1;
                lk_data = lk_data | buf_data_q[i];
            end
        end

        pop  = (state_q == IDLE) && (count_q != '0);
        push = memRequest && !dup && ((count_q != (QA+1)'(QDEPTH)) || pop);
        if (memRequest && !dup && !push)
            drop_count_d = sat_inc8(drop_count_q);

        if (push) begin
            q_mem_d[tail_q] = requestAddress;
            tail_d          = tail_q + 1'b1;
        end
        if (pop)
            head_d = head_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        if (storeValid) begin
            for (int i = 0; i < BUF_ENTRIES; i++)
                if (buf_addr_q[i] == storeAddr)
                    buf_valid_d[i] = 1'b0;
            if (in_flight && (inflight_addr_q == storeAddr))
                inflight_kill_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    inflight_addr_d = q_mem_q[head_q];
                    inflight_kill_d = 1'b0;
                    state_d         = REQ;
                end
            end
            REQ: begin
                if (memReadAck)
                    state_d = WAIT;
            end
            WAIT: begin
                if (memReadValid) begin
                    state_d = IDLE;
                    // A store landing on the fill edge kills the fill as well.
                    fill = !inflight_kill_q && !(storeValid && (storeAddr == inflight_addr_q));
                end
            end
            default: state_d = IDLE;
        endcase

        if (fill) begin
            buf_valid_d[rep_ptr_q] = 1'b1;
            buf_addr_d[rep_ptr_q]  = inflight_addr_q;
            buf_data_d[rep_ptr_q]  = memReadData;
            rep_ptr_d              = rep_ptr_q + 1'b1;
        end

        queue_full_d  = (count_d == (QA+1)'(QDEPTH));
        lookup_hit_d  = lookupValid && lk_hit;
        lookup_data_d = (lookupValid && lk_hit) ? lk_data : '0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            inflight_kill_q <= 1'b0;
            buf_valid_q     <= '0;
            rep_ptr_q       <= '0;
            lookup_hit_q    <= 1'b0;
            lookup_data_q   <= '0;
            queue_full_q    <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            inflight_kill_q <= inflight_kill_d;
            buf_valid_q     <= buf_valid_d;
            rep_ptr_q       <= rep_ptr_d;
            lookup_hit_q    <= lookup_hit_d;
            lookup_data_q   <= lookup_data_d;
            queue_full_q    <= queue_full_d;
            drop_count_q    <= drop_count_d;
        end
    end

    // Payload storage is qualified by control state, so it needs no reset.
    always_ff @(posedge clk) begin
        q_mem_q         <= q_mem_d;
        inflight_addr_q <= inflight_addr_d;
        buf_addr_q      <= buf_addr_d;
        buf_data_q      <= buf_data_d;
    end

    assign memReadReq  = (state_q == REQ);
    assign memReadAddr = (state_q == REQ) ? inflight_addr_q : '0;
    assign lookupHit   = lookup_hit_q;
    assign lookupData  = lookup_data_q;
    assign queueFull   = queue_full_q;
    assign dropCount   = drop_count_q;
endmodule

// File: tb/tb_prefetch_responder.sv
// Directed bench for prefetch_responder: a vector table for the basic fill/lookup
// flow plus hand-written sequences for queueing, kills, replacement and reset.
module tb_prefetch_responder;
    logic        clk = 1'b0;
    logic        rstN;
    logic        memRequest;
    logic [15:0] requestAddress;
    logic        memReadReq;
    logic [15:0] memReadAddr;
    logic        memReadAck;
    logic        memReadValid;
    logic [15:0] memReadData;
    logic        lookupValid;
    logic [15:0] lookupAddr;
    logic        lookupHit;
    logic [15:0] lookupData;
    logic        storeValid;
    logic [15:0] storeAddr;
    logic        queueFull;
    logic [7:0]  dropCount;

    int n_chk  = 0;
    int n_fail = 0;

    prefetch_responder #(.QDEPTH(4), .BUF_ENTRIES(8)) dut (
        .clk(clk), .rstN(rstN),
        .memRequest(memRequest), .requestAddress(requestAddress),
        .memReadReq(memReadReq), .memReadAddr(memReadAddr),
        .memReadAck(memReadAck), .memReadValid(memReadValid), .memReadData(memReadData),
        .lookupValid(lookupValid), .lookupAddr(lookupAddr),
        .lookupHit(lookupHit), .lookupData(lookupData),
        .storeValid(storeValid), .storeAddr(storeAddr),
        .queueFull(queueFull), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mreq;
        logic [15:0] raddr;
        logic        ack;
        logic        dv;
        logic [15:0] dat;
        logic        lv;
        logic [15:0] la;
        logic        sv;
        logic [15:0] sa;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_hit;
        logic [15:0] e_data;
        logic        e_full;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        memRequest = 0; requestAddress = 0; memReadAck = 0; memReadValid = 0;
        memReadData = 0; lookupValid = 0; lookupAddr = 0; storeValid = 0; storeAddr = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rstN = 0;
        tick();
        tick();
        chk("rst_memReadReq", 16'(memReadReq), 16'h0);
        chk("rst_memReadAddr", memReadAddr, 16'h0);
        chk("rst_lookupHit", 16'(lookupHit), 16'h0);
        chk("rst_lookupData", lookupData, 16'h0);
        chk("rst_queueFull", 16'(queueFull), 16'h0);
        chk("rst_dropCount", 16'(dropCount), 16'h0);
        rstN = 1;
    endtask

    // Single request through to a buffer fill; assumes IDLE with an empty queue.
    task automatic fill(input logic [15:0] a, input logic [15:0] d);
        memRequest = 1; requestAddress = a;
        tick();
        memRequest = 0;
        tick();
        memReadAck = 1;
        tick();
        memReadAck = 0; memReadValid = 1; memReadData = d;
        tick();
        memReadValid = 0;
    endtask

    task automatic lookup(input string nm, input logic [15:0] a, input logic eh, input logic [15:0] ed);
        lookupValid = 1; lookupAddr = a;
        tick();
        lookupValid = 0;
        chk({nm, "_hit"}, 16'(lookupHit), 16'(eh));
        chk({nm, "_data"}, lookupData, ed);
    endtask

    initial begin
        rstN = 0;
        set_idle();

        //            mreq raddr     ack dv dat       lv la        sv sa        req addr      hit data      full drop
        vecs[0]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0};

        // Basic request / ack / data / lookup, then store-vs-lookup on one edge.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            memRequest = vecs[i].mreq; requestAddress = vecs[i].raddr;
            memReadAck = vecs[i].ack; memReadValid = vecs[i].dv; memReadData = vecs[i].dat;
            lookupValid = vecs[i].lv; lookupAddr = vecs[i].la;
            storeValid = vecs[i].sv; storeAddr = vecs[i].sa;
            tick();
            chk($sformatf("v%0d_req", i), 16'(memReadReq), 16'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), memReadAddr, vecs[i].e_addr);
            chk($sformatf("v%0d_hit", i), 16'(lookupHit), 16'(vecs[i].e_hit));
            chk($sformatf("v%0d_data", i), lookupData, vecs[i].e_data);
            chk($sformatf("v%0d_full", i), 16'(queueFull), 16'(vecs[i].e_full));
            chk($sformatf("v%0d_drop", i), 16'(dropCount), 16'(vecs[i].e_drop));
        end
        set_idle();

        // Queue fill with a stalled ack, dedup, push-on-pop, drop saturation.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            memRequest = 1; requestAddress = 16'h2100 + 16'(i);
            tick();
        end
        chk("q_req", 16'(memReadReq), 16'h1);
        chk("q_addr", memReadAddr, 16'h2100);
        chk("q_full", 16'(queueFull), 16'h1);
        chk("q_drop", 16'(dropCount), 16'd2);
        requestAddress = 16'h2102;
        tick();
        chk("q_dup_queued", 16'(dropCount), 16'd2);
        requestAddress = 16'h2100;
        tick();
        chk("q_dup_inflight", 16'(dropCount), 16'd2);
        memRequest = 0; memReadAck = 1;
        tick();
        chk("q_ack_req", 16'(memReadReq), 16'h0);
        memReadAck = 0; memReadValid = 1; memReadData = 16'hAAAA;
        tick();
        memReadValid = 0; memRequest = 1; requestAddress = 16'h2200;
        tick();
        chk("q_pushpop_req", 16'(memReadReq), 16'h1);
        chk("q_pushpop_addr", memReadAddr, 16'h2101);
        chk("q_pushpop_full", 16'(queueFull), 16'h1);
        chk("q_pushpop_drop", 16'(dropCount), 16'd2);
        requestAddress = 16'h2100;
        tick();
        chk("q_dup_buffer", 16'(dropCount), 16'd2);
        for (int i = 0; i < 260; i++) begin
            requestAddress = 16'h3000 + 16'(i);
            tick();
        end
        chk("q_drop_sat", 16'(dropCount), 16'd255);
        set_idle();

        // Store kills an in-flight read (earlier edge, and same edge as data).
        do_reset();
        memRequest = 1; requestAddress = 16'h1000;
        tick();
        memRequest = 0;
        tick();
        memReadAck = 1;
        tick();
        memReadAck = 0; storeValid = 1; storeAddr = 16'h1000;
        tick();
        storeValid = 0; memReadValid = 1; memReadData = 16'h1111;
        tick();
        memReadValid = 0;
        lookup("kill_wait", 16'h1000, 1'b0, 16'h0);
        memRequest = 1; requestAddress = 16'h1400;
        tick();
        memRequest = 0;
        tick();
        memReadAck = 1;
        tick();
        memReadAck = 0; memReadValid = 1; memReadData = 16'h2222;
        storeValid = 1; storeAddr = 16'h1400;
        tick();
        set_idle();
        lookup("kill_same_edge", 16'h1400, 1'b0, 16'h0);
        fill(16'h1000, 16'h3333);
        lookup("kill_cleared", 16'h1000, 1'b1, 16'h3333);

        // Round-robin replacement over nine fills.
        do_reset();
        for (int i = 0; i < 9; i++)
            fill(16'h4000 + 16'(i * 16), 16'h5000 + 16'(i));
        lookup("rr_first", 16'h4000, 1'b0, 16'h0);
        lookup("rr_ninth", 16'h4080, 1'b1, 16'h5008);
        lookup("rr_second", 16'h4010, 1'b1, 16'h5001);
        lookup("rr_eighth", 16'h4070, 1'b1, 16'h5007);

        // Fill and lookup of the same address on one edge.
        do_reset();
        memRequest = 1; requestAddress = 16'h2000;
        tick();
        memRequest = 0;
        tick();
        memReadAck = 1;
        tick();
        memReadAck = 0; memReadValid = 1; memReadData = 16'h2D2D;
        lookupValid = 1; lookupAddr = 16'h2000;
        tick();
        set_idle();
        chk("fill_lookup_same_hit", 16'(lookupHit), 16'h0);
        lookup("fill_lookup_next", 16'h2000, 1'b1, 16'h2D2D);

        // Asynchronous reset while in REQ with a non-empty queue.
        do_reset();
        fill(16'h6000, 16'h6666);
        memRequest = 1; requestAddress = 16'h6100;
        tick();
        requestAddress = 16'h6200;
        tick();
        requestAddress = 16'h6300;
        tick();
        memRequest = 0;
        chk("ar_pre_req", 16'(memReadReq), 16'h1);
        chk("ar_pre_addr", memReadAddr, 16'h6100);
        #2;
        rstN = 0;
        #1;
        chk("ar_async_req", 16'(memReadReq), 16'h0);
        chk("ar_async_addr", memReadAddr, 16'h0);
        tick();
        rstN = 1;
        memReadValid = 1; memReadData = 16'h7777;
        tick();
        memReadValid = 0;
        chk("ar_post_req", 16'(memReadReq), 16'h0);
        chk("ar_post_full", 16'(queueFull), 16'h0);
        chk("ar_post_drop", 16'(dropCount), 16'h0);
        tick();
        chk("ar_queue_empty", 16'(memReadReq), 16'h0);
        lookup("ar_lookup_buf", 16'h6000, 1'b0, 16'h0);
        lookup("ar_lookup_inflight", 16'h6100, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
